// File: rtl/encode.sv
// ---------------------------------------------------------------------------
// encode: synchronised 7-input priority encoder with active-low requests
// and an active-low enable.
//
// Raw board inputs (Datain, n_EN) are brought into the clk domain through a
// SYNC_STAGES-deep flop chain. The last stage selects the highest-numbered
// active request, and the result is registered onto D/ET. Code 0 means "no
// request", so Datain[i] maps to code i+1.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth, legal range 2..4 (default 2)
//
// Ports:
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   n_EN   : encoder enable, active-low, asynchronous to clk
//   Datain : request lines, active-low, asynchronous to clk
//   D      : registered code of highest active request (0 when none)
//   ET     : registered valid flag (enabled and any request active)
//
// Latency from a stable input change to D/ET is SYNC_STAGES+1 edges.
// ---------------------------------------------------------------------------
module encode #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       n_EN,
    input  logic [6:0] Datain,
    output logic [2:0] D,
    output logic       ET
);

    localparam int SW = 8;  // {n_EN, Datain[6:0]} carried together

    // Enable and data share one chain so both see equal delay; a
    // simultaneous change of n_EN and Datain therefore arrives together.
    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;

    logic [6:0] req_n;
    logic       en;
    logic [2:0] code;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // All-ones = every request inactive and the encoder disabled.
            sync_q <= '1;
        end else begin
            sync_q[0] <= {n_EN, Datain};
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
        end
    end

    assign req_n = sync_q[SYNC_STAGES-1][6:0];
    assign en    = ~sync_q[SYNC_STAGES-1][7];

    // Ascending scan: later (higher-index) active bits overwrite earlier
    // ones, giving Datain[6] top priority.
    always_comb begin
        code = 3'd0;
        for (int i = 0; i < 7; i++)
            if (!req_n[i])
                code = 3'(i + 1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            D  <= 3'd0;
            ET <= 1'b0;
        end else if (en) begin
            D  <= code;
            ET <= (code != 3'd0);
        end else begin
            D  <= 3'd0;
            ET <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encode.sv
// ---------------------------------------------------------------------------
// tb_encode: directed self-checking bench for encode (SYNC_STAGES = 2).
// Inputs change on the falling edge; outputs are sampled 2 ns after rising
// edges. Each step checks the old value one edge before the expected
// latency and the new value exactly at it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encode;

    logic       clk;
    logic       n_rst;
    logic       n_EN;
    logic [6:0] Datain;
    logic [2:0] D;
    logic       ET;

    int n_assert = 0;
    int n_fail   = 0;

    encode #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .n_EN   (n_EN),
        .Datain (Datain),
        .D      (D),
        .ET     (ET)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] ed, input logic ee);
        n_assert++;
        assert ({D, ET} === {ed, ee}) else begin
            n_fail++;
            $error("FAIL %s: observed D=%0d ET=%0b, expected D=%0d ET=%0b",
                   tag, D, ET, ed, ee);
        end
    endtask

    // Drive a new input combination at a falling edge, then check that the
    // old output holds after 2 rising edges, the new one appears on the 3rd,
    // and it is still present at the end of the hold window.
    task automatic apply(input string tag, input logic [6:0] din, input logic en_n,
                         input logic [2:0] od, input logic oe,
                         input logic [2:0] nd, input logic ne, input int hold);
        @(negedge clk);
        Datain = din;
        n_EN   = en_n;
        repeat (2) @(posedge clk);
        #2 chk({tag, "_old"}, od, oe);
        @(posedge clk);
        #2 chk({tag, "_new"}, nd, ne);
        repeat (hold - 3) @(posedge clk);
        #2 chk({tag, "_hold"}, nd, ne);
    endtask

    initial begin
        logic [6:0] walk;

        // Reset with a request present: outputs stay 0/0 throughout.
        n_rst  = 1'b0;
        n_EN   = 1'b0;
        Datain = 7'b1111110;
        #1 chk("rst_imm", 3'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2 chk("rst_hold", 3'd0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk("rel_e2", 3'd0, 1'b0);
        @(posedge clk);
        #2 chk("rel_e3", 3'd1, 1'b1);

        // Walking zero, enabled: 10 cycles (100 ns) on, 10 off.
        apply("idle", 7'b1111111, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 10);
        for (int i = 0; i < 7; i++) begin
            walk = 7'b1111111;
            walk[i] = 1'b0;
            apply($sformatf("walk%0d", i), walk, 1'b0, 3'd0, 1'b0, 3'(i + 1), 1'b1, 10);
            apply($sformatf("walk%0d_off", i), 7'b1111111, 1'b0, 3'(i + 1), 1'b1, 3'd0, 1'b0, 10);
        end

        // Walking zero, disabled: nothing ever shows.
        apply("dis_idle", 7'b1111111, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 10);
        for (int i = 0; i < 7; i++) begin
            walk = 7'b1111111;
            walk[i] = 1'b0;
            apply($sformatf("dis%0d", i), walk, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 10);
            apply($sformatf("dis%0d_off", i), 7'b1111111, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 10);
        end

        // Priority among multiple active bits.
        apply("pri_1010101", 7'b1010101, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 10);
        apply("pri_1111100", 7'b1111100, 1'b0, 3'd6, 1'b1, 3'd2, 1'b1, 10);
        apply("pri_0000000", 7'b0000000, 1'b0, 3'd2, 1'b1, 3'd7, 1'b1, 10);
        apply("pri_0011110", 7'b0011110, 1'b0, 3'd7, 1'b1, 3'd7, 1'b1, 10);
        apply("pri_1110011", 7'b1110011, 1'b0, 3'd7, 1'b1, 3'd4, 1'b1, 10);

        // Enable toggling every 1400 ns with a fixed request (code 4).
        apply("en_on0",  7'b1110111, 1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 140);
        apply("en_off0", 7'b1110111, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 140);
        apply("en_on1",  7'b1110111, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 140);
        apply("en_off1", 7'b1110111, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 140);

        // Simultaneous enable and data change.
        apply("simul", 7'b1101111, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 10);

        // Short reset pulse mid-run: immediate clear, no memory afterwards.
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1 chk("midrst_imm", 3'd0, 1'b0);
        #2 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk("midrst_e2", 3'd0, 1'b0);
        @(posedge clk);
        #2 chk("midrst_e3", 3'd5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
